// File: rtl/bpu_update_arb_pkg.sv
// Shared types for the BPU update arbiter: update payload and grant encoding.
package bpu_update_arb_pkg;

  // Training/update payload presented to the BPU.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        btb_update;
    logic        bht_update;
    logic        lpht_update;
    logic        flush;
  } bpu_update_t;

  localparam int BPU_UPD_W = $bits(bpu_update_t);

  // Which requester owns the update port this cycle.
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_BE        = 2'd1,
    ARB_FE        = 2'd2,
    ARB_FE_FORCED = 2'd3
  } bpu_arb_grant_e;

  // True when the grant pops the front-correction queue.
  function automatic logic is_front_grant(input bpu_arb_grant_e g);
    return (g == ARB_FE) || (g == ARB_FE_FORCED);
  endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// Small circular queue for front-end corrections.
// A clear empties the queue by snapping the read pointer to the write pointer.
module bpu_upd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  // Pointer and occupancy update; clear wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bpu_update_arb.sv
// Arbiter for the single BPU update port: backend resolution updates have
// priority over queued front-end corrections, with a starvation guard.
// Optional counters enabled by defining BPU_ARB_PERF_EN.
module bpu_update_arb
  import bpu_update_arb_pkg::*;
#(
  parameter int FE_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fe_valid_i,
  input  bpu_update_t fe_update_i,
  output logic        fe_ready_o,
  input  logic        be_valid_i,
  input  bpu_update_t be_update_i,
  output logic        be_ready_o,
  input  logic        be_flush_i,
`ifdef BPU_ARB_PERF_EN
  output logic [31:0] perf_fe_drop_o,
  output logic [31:0] perf_starve_o,
`endif
  output bpu_update_t update_o,
  output logic        update_valid_o
);

  localparam int CNT_W    = $clog2(FE_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BPU_UPD_W-1:0] fifo_head;
  logic [CNT_W-1:0]     fifo_count;

  bpu_arb_grant_e       grant_raw, grant;
  logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
  bpu_update_t          update_q, update_d;
  logic                 update_valid_q, update_valid_d;

  assign fe_ready_o = ~fifo_full;
  assign fifo_push  = fe_valid_i & fe_ready_o & ~be_flush_i;
  assign fifo_pop   = is_front_grant(grant);

  bpu_upd_fifo #(
    .DEPTH (FE_DEPTH),
    .WIDTH (BPU_UPD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (be_flush_i),
    .data_i  (fe_update_i),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Grant selection; a redirect cancels any front pop, handing the slot to the backend if it is asking.
  always_comb begin
    grant_raw = ARB_IDLE;
    if ((starve_cnt_q == STARVE_W'(STARVE_LIMIT)) && !fifo_empty) grant_raw = ARB_FE_FORCED;
    else if (be_valid_i)                                         grant_raw = ARB_BE;
    else if (!fifo_empty)                                        grant_raw = ARB_FE;
    grant = grant_raw;
    if (be_flush_i && is_front_grant(grant_raw)) grant = be_valid_i ? ARB_BE : ARB_IDLE;
  end

  assign be_ready_o = (grant == ARB_BE);

  // Next output payload and starvation count.
  always_comb begin
    update_d       = update_q;
    update_valid_d = 1'b0;
    case (grant)
      ARB_BE: begin
        update_valid_d = 1'b1;
        update_d       = be_update_i;
      end
      ARB_FE, ARB_FE_FORCED: begin
        update_valid_d = 1'b1;
        update_d       = bpu_update_t'(fifo_head);
      end
      default: ;
    endcase
    starve_cnt_d = starve_cnt_q;
    if (be_flush_i || (fifo_count == '0) || is_front_grant(grant)) starve_cnt_d = '0;
    else if ((grant == ARB_BE) && (starve_cnt_q != STARVE_W'(STARVE_LIMIT)))
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
  end

  // Output register and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_q       <= '0;
      update_valid_q <= 1'b0;
      starve_cnt_q   <= '0;
    end else begin
      update_q       <= update_d;
      update_valid_q <= update_valid_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end

  assign update_o       = update_q;
  assign update_valid_o = update_valid_q;

`ifdef BPU_ARB_PERF_EN
  logic [31:0] perf_fe_drop_q, perf_fe_drop_d;
  logic [31:0] perf_starve_q,  perf_starve_d;

  // Drops count every queued entry plus the front request presented in the redirect cycle.
  always_comb begin
    perf_fe_drop_d = perf_fe_drop_q;
    perf_starve_d  = perf_starve_q;
    if (be_flush_i) perf_fe_drop_d = perf_fe_drop_q + 32'(fifo_count) + 32'(fe_valid_i);
    if (grant == ARB_FE_FORCED) perf_starve_d = perf_starve_q + 32'd1;
  end

  // Performance counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fe_drop_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      perf_fe_drop_q <= perf_fe_drop_d;
      perf_starve_q  <= perf_starve_d;
    end
  end

  assign perf_fe_drop_o = perf_fe_drop_q;
  assign perf_starve_o  = perf_starve_q;
`endif

endmodule

// File: tb/tb_bpu_update_arb.sv
// Directed bench for bpu_update_arb with an in-order output scoreboard.
module tb_bpu_update_arb;
  import bpu_update_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fe_valid_i = 1'b0;
  bpu_update_t fe_update_i = '0;
  logic        fe_ready_o;
  logic        be_valid_i = 1'b0;
  bpu_update_t be_update_i = '0;
  logic        be_ready_o;
  logic        be_flush_i = 1'b0;
  bpu_update_t update_o;
  logic        update_valid_o;
`ifdef BPU_ARB_PERF_EN
  logic [31:0] perf_fe_drop_o;
  logic [31:0] perf_starve_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bpu_update_t sb[$];

  always #5 clk = ~clk;

  bpu_update_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fe_valid_i     (fe_valid_i),
    .fe_update_i    (fe_update_i),
    .fe_ready_o     (fe_ready_o),
    .be_valid_i     (be_valid_i),
    .be_update_i    (be_update_i),
    .be_ready_o     (be_ready_o),
    .be_flush_i     (be_flush_i),
`ifdef BPU_ARB_PERF_EN
    .perf_fe_drop_o (perf_fe_drop_o),
    .perf_starve_o  (perf_starve_o),
`endif
    .update_o       (update_o),
    .update_valid_o (update_valid_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bpu_update_t mk(input logic [31:0] pc);
    bpu_update_t u;
    u            = '0;
    u.pc         = pc;
    u.target     = pc + 32'h100;
    u.taken      = pc[2];
    u.btb_update = pc[3];
    u.bht_update = 1'b1;
    return u;
  endfunction

  task automatic step(input logic fv, input logic [31:0] fpc, input logic bv,
                      input logic [31:0] bpc, input logic fl);
    @(negedge clk);
    fe_valid_i  = fv;
    fe_update_i = mk(fpc);
    be_valid_i  = bv;
    be_update_i = mk(bpc);
    be_flush_i  = fl;
    #1;
  endtask

  // Output monitor: every valid update must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && update_valid_o) begin
      $display("txn %0t pc=%h target=%h", $time, update_o.pc, update_o.target);
      if (sb.size() == 0) chk("unexpected_update", update_valid_o, 1'b0);
      else chk("sb_payload", update_o, sb.pop_front());
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", update_valid_o, 1'b0);
    chk("rst_update", update_o, '0);
    chk("rst_fe_ready", fe_ready_o, 1'b1);
    chk("rst_be_ready", be_ready_o, 1'b0);
`ifdef BPU_ARB_PERF_EN
    chk("rst_perf_starve", perf_starve_o, 32'd0);
    chk("rst_perf_drop", perf_fe_drop_o, 32'd0);
`endif
    rst_n = 1'b1;

    // Front-only latency: enqueue, pop, output
    step(1, 32'h1C00_0004, 0, 0, 0);
    chk("lat_fe_ready", fe_ready_o, 1'b1);
    sb.push_back(mk(32'h1C00_0004));
    step(0, 0, 0, 0, 0);
    chk("lat_c2_valid", update_valid_o, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("lat_c3_valid", update_valid_o, 1'b1);
    chk("lat_c3_pc", update_o.pc, 32'h1C00_0004);
    step(0, 0, 0, 0, 0);

    // Starvation guard
    step(1, 32'h3000_0000, 1, 32'h8000_0000, 0);
    chk("stv_be_ready_0", be_ready_o, 1'b1);
    sb.push_back(mk(32'h8000_0000));
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, 32'h8000_0000 + 32'(i * 4), 0);
      chk($sformatf("stv_be_ready_%0d", i), be_ready_o, 1'b1);
      sb.push_back(mk(32'h8000_0000 + 32'(i * 4)));
    end
    step(0, 0, 1, 32'h8000_0014, 0);
    chk("stv_forced_be_ready", be_ready_o, 1'b0);
    sb.push_back(mk(32'h3000_0000));
    step(0, 0, 1, 32'h8000_0014, 0);
    chk("stv_resume_be_ready", be_ready_o, 1'b1);
    sb.push_back(mk(32'h8000_0014));
    step(0, 0, 0, 0, 0);
`ifdef BPU_ARB_PERF_EN
    chk("stv_perf_starve", perf_starve_o, 32'd1);
`endif
    step(0, 0, 0, 0, 0);

    // Queue full while backend is busy
    step(1, 32'h4000_0000, 1, 32'h9000_0000, 0);
    chk("full_rdy_c0", fe_ready_o, 1'b1);
    sb.push_back(mk(32'h9000_0000));
    step(1, 32'h4000_0004, 1, 32'h9000_0004, 0);
    chk("full_rdy_c1", fe_ready_o, 1'b1);
    sb.push_back(mk(32'h9000_0004));
    step(1, 32'h4000_0008, 1, 32'h9000_0008, 0);
    chk("full_rdy_c2", fe_ready_o, 1'b0);
    sb.push_back(mk(32'h9000_0008));
    step(1, 32'h4000_0008, 0, 0, 0);
    chk("full_rdy_popcycle", fe_ready_o, 1'b0);
    sb.push_back(mk(32'h4000_0000));
    step(1, 32'h4000_0008, 0, 0, 0);
    chk("full_rdy_after_pop", fe_ready_o, 1'b1);
    sb.push_back(mk(32'h4000_0004));
    step(0, 0, 0, 0, 0);
    sb.push_back(mk(32'h4000_0008));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Flush with two queued entries plus concurrent requests
    step(1, 32'h5000_0000, 1, 32'hA000_0000, 0);
    sb.push_back(mk(32'hA000_0000));
    step(1, 32'h5000_0004, 1, 32'hA000_0004, 0);
    sb.push_back(mk(32'hA000_0004));
    step(1, 32'h5000_0008, 1, 32'hA000_0008, 1);
    chk("flush_fe_ready", fe_ready_o, 1'b0);
    chk("flush_be_ready", be_ready_o, 1'b1);
    sb.push_back(mk(32'hA000_0008));
    step(0, 0, 0, 0, 0);
    chk("flush_out_valid", update_valid_o, 1'b1);
    chk("flush_out_pc", update_o.pc, 32'hA000_0008);
    chk("flush_fe_ready_after", fe_ready_o, 1'b1);
`ifdef BPU_ARB_PERF_EN
    chk("flush_perf_drop", perf_fe_drop_o, 32'd3);
`endif
    step(0, 0, 0, 0, 0);
    chk("flush_no_fe_out", update_valid_o, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("flush_no_fe_out2", update_valid_o, 1'b0);

    // Pointer wrap: ten streamed front updates
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h2000_0000 + 32'(i * 4), 0, 0, 0);
      chk($sformatf("wrap_fe_ready_%0d", i), fe_ready_o, 1'b1);
      sb.push_back(mk(32'h2000_0000 + 32'(i * 4)));
    end
    repeat (3) step(0, 0, 0, 0, 0);
    chk("wrap_drained", sb.size(), 0);
    chk("wrap_idle_valid", update_valid_o, 1'b0);

    // Asynchronous reset with one queued entry
    step(1, 32'h6000_0000, 1, 32'hB000_0000, 0);
    sb.push_back(mk(32'hB000_0000));
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    fe_valid_i = 1'b0;
    be_valid_i = 1'b0;
    #1;
    chk("arst_valid", update_valid_o, 1'b0);
    chk("arst_update", update_o, '0);
    chk("arst_fe_ready", fe_ready_o, 1'b1);
    chk("arst_be_ready", be_ready_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(0, 0, 0, 0, 0);
    chk("arst_no_stale", update_valid_o, 1'b0);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpu_update_arb.md
Name: bpu_update_arb

Overview:
- Owns the single BPU training/update port.
- Arbitrates between two requesters:
  - backend branch-resolution updates (execute/commit);
  - front-end predecode corrections (false-taken predictions on non-branch instructions).
- Front corrections are buffered in a small queue. Backend has priority, with a starvation guard.
- A backend redirect discards queued front updates as wrong-path.

Parameters:
- FE_DEPTH, 2, front-update queue entries; power of two, ≥2.
- STARVE_LIMIT, 4, consecutive backend grants while the queue is non-empty before one front grant is forced; ≥1.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- fe_valid_i  input  1  front correction request
- fe_update_i  input  bpu_update_t  front correction payload
- fe_ready_o  output  1  queue can accept this cycle
- be_valid_i  input  1  backend update request
- be_update_i  input  bpu_update_t  backend update payload
- be_ready_o  output  1  backend request granted this cycle
- be_flush_i  input  1  backend redirect; front queue becomes wrong-path
- update_o  output  bpu_update_t  registered update to BPU
- update_valid_o  output  1  update_o valid this cycle

Behaviour:
- Reset (async, rst_n=0):
  - queue empty; starve_cnt=0;
  - update_valid_o=0, update_o=all-zero;
  - fe_ready_o=1, be_ready_o=0 (combinational from reset state).
- Queue:
  - circular buffer with rd/wr pointers of log2(FE_DEPTH) bits, wrapping naturally, plus count of log2(FE_DEPTH)+1 bits.
  - fe_ready_o = (count != FE_DEPTH), computed from registered state only. A full queue does not accept, even when popping that cycle.
  - Enqueue when fe_valid_i & fe_ready_o & ~be_flush_i.
- Grant (combinational, each cycle):
  - Priority 1, forced front: starve_cnt==STARVE_LIMIT and queue non-empty. be_ready_o=0; the backend holds its request.
  - Priority 2, backend: be_valid_i. be_ready_o=1.
  - Priority 3, front: queue non-empty. Pop the head.
  - Otherwise idle.
- Output register:
  - Next cycle, update_valid_o=1 and update_o = the granted payload; otherwise update_valid_o=0 and update_o holds its value.
  - Latency: backend 1 cycle; front minimum 2 cycles (enqueue, then pop). There is no bypass.
  - The BPU always accepts; there is no back-pressure on update_o.
- starve_cnt:
  - +1 on a backend grant while the queue is non-empty, saturating at STARVE_LIMIT.
  - Cleared on any front grant, when the queue is empty, or on be_flush_i.
- be_flush_i:
  - Next state: count=0, rd=wr pointer, starve_cnt=0.
  - A same-cycle front enqueue is dropped.
  - A same-cycle front pop is cancelled: update_valid_o=0 next cycle.
  - A same-cycle backend grant still proceeds: the resolving branch trains the BPU.
  - If forced-front was selected in the flush cycle, it is converted to a backend grant when be_valid_i=1.
- Simultaneous enqueue and pop on a non-full queue: count is unchanged and both pointers advance.
- Reset asserted mid-operation: all state clears immediately and pending entries are lost.
- Payload is passed unmodified. Flush/btb/lpht/bht update bits are the requester's responsibility.

Optional Feature:
- BPU_ARB_PERF_EN, when defined:
  - Adds outputs perf_fe_drop_o[31:0], counting queued entries plus in-flight enqueues discarded by be_flush_i.
  - Adds perf_starve_o[31:0], counting forced front grants.
  - Both reset to 0, wrap at 2^32, and are counted in the same cycle as the event.
- When not defined: no ports and no counters. Functional behaviour is identical.

Decomposition:
- Shared package/header bpu.svh:
  - bpu_update_t (existing);
  - localparam BPU_ARB_GRANT enum {ARB_IDLE, ARB_BE, ARB_FE, ARB_FE_FORCED}.
- One sub-module: bpu_upd_fifo, a parameterised circular queue with push, pop, clear, count, full and empty signals. The arbiter wraps it plus the grant logic and output register.

Test Plan:
- Reset release, fe_valid_i=1 with pc=0x1C00_0004, be_valid_i=0:
  - cycle 1: fe_ready_o=1, enqueue;
  - cycle 2: pop;
  - cycle 3: update_valid_o=1 with the same payload.
  - Payload is never visible before cycle 3.
- be_valid_i held 1 continuously, one front entry queued, STARVE_LIMIT=4:
  - backend granted 4 cycles;
  - 5th cycle be_ready_o=0 and the front entry is output;
  - 6th cycle backend resumes.
  - perf_starve_o=1 (macro on).
- Fill the queue with 2 front entries while the backend is busy:
  - fe_ready_o=0; a 3rd request is not accepted.
  - After one pop, fe_ready_o=1 the following cycle.
- 2 entries queued, be_flush_i=1 with be_valid_i=1 and fe_valid_i=1 in the same cycle:
  - next cycle update_o = backend payload;
  - queue empty; no front update ever emitted;
  - perf_fe_drop_o=3.
- Pointer wrap: stream 10 front-only updates with distinct pc:
  - outputs appear in order, no loss or duplication across wrap;
  - count returns to 0.
- rst_n asserted mid-stream with the queue holding 1 entry:
  - outputs go immediately to update_valid_o=0 and fe_ready_o=1;
  - after release no stale entry is emitted.
